// File: rtl/icache_refill_controller.sv
// Instruction-cache refill controller: fetches a missing line beat by beat, writes it into the arrays,
// and walks every index to invalidate on fence.i. Optional RAFI_ICACHE_MISS_COUNTER_EN adds a miss_count output.
module icache_refill_controller #(
  parameter int LINE_WIDTH  = 128,
  parameter int BUS_WIDTH   = 32,
  parameter int INDEX_WIDTH = 6,
  localparam int BEATS        = LINE_WIDTH / BUS_WIDTH,
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
  localparam int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_valid,
  input  logic [31:0]            miss_addr,
  input  logic                   flush_req,
  output logic                   stall,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [BUS_WIDTH-1:0]   mem_resp_data,
  output logic                   array_we,
  output logic [INDEX_WIDTH-1:0] array_index,
  output logic [TAG_WIDTH-1:0]   array_tag,
  output logic                   array_valid,
  output logic [LINE_WIDTH-1:0]  array_line,
  output logic                   refill_done,
`ifdef RAFI_ICACHE_MISS_COUNTER_EN
  output logic                   flush_done,
  output logic [31:0]            miss_count
`else
  output logic                   flush_done
`endif
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
  localparam logic [31:0]            BEAT_BYTES = 32'(BUS_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, INVAL} state_t;

  state_t                   state;
  logic [31-OFFSET_WIDTH:0] base_hi;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [INDEX_WIDTH-1:0]   inval_idx;
  logic                     flush_pend;
  logic [LINE_WIDTH-1:0]    line_buf;
  logic [LINE_WIDTH-1:0]    line_next;
  logic                     unused_offset;

  assign unused_offset = ^miss_addr[OFFSET_WIDTH-1:0];
  assign stall = (state != IDLE) | miss_valid | flush_req | flush_pend;

  // Line buffer with the arriving beat merged into its slot
  always_comb begin
    line_next = line_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == BEAT_W'(b)) line_next[b*BUS_WIDTH +: BUS_WIDTH] = mem_resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      base_hi       <= '0;
      beat_cnt      <= '0;
      inval_idx     <= '0;
      flush_pend    <= 1'b0;
      line_buf      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      array_we      <= 1'b0;
      array_index   <= '0;
      array_tag     <= '0;
      array_valid   <= 1'b0;
      array_line    <= '0;
      refill_done   <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      array_we    <= 1'b0;
      array_index <= '0;
      array_tag   <= '0;
      array_valid <= 1'b0;
      array_line  <= '0;
      refill_done <= 1'b0;
      flush_done  <= 1'b0;
      // A flush seen while busy is remembered and served from IDLE ahead of any miss
      if (flush_req && state != IDLE) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_req || flush_pend) begin
            state       <= INVAL;
            flush_pend  <= 1'b0;
            array_we    <= 1'b1;
            array_index <= inval_idx;
          end else if (miss_valid) begin
            state         <= REQ;
            base_hi       <= miss_addr[31:OFFSET_WIDTH];
            beat_cnt      <= '0;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {miss_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            line_buf <= line_next;
            if (beat_cnt == LAST_BEAT) begin
              state       <= WRITE;
              array_we    <= 1'b1;
              array_valid <= 1'b1;
              array_index <= base_hi[INDEX_WIDTH-1:0];
              array_tag   <= base_hi[31-OFFSET_WIDTH:INDEX_WIDTH];
              array_line  <= line_next;
              refill_done <= 1'b1;
            end else begin
              state         <= REQ;
              beat_cnt      <= beat_cnt + 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + BEAT_BYTES;
            end
          end
        end
        WRITE: state <= IDLE;
        INVAL: begin
          // inval_idx names the index currently on the array port; it wraps back to 0 after the last one
          inval_idx <= inval_idx + 1'b1;
          if (inval_idx == LAST_INDEX) begin
            state <= IDLE;
          end else begin
            array_we    <= 1'b1;
            array_index <= inval_idx + 1'b1;
            flush_done  <= (inval_idx + 1'b1) == LAST_INDEX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAFI_ICACHE_MISS_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) miss_count <= '0;
    else if (refill_done) miss_count <= miss_count + 32'd1;
  end
`endif

endmodule
